sigmoid_vector_unit: RTL and testbench

SIGMOID_VECTOR_UNIT -- requirements
Module: sigmoid_vector_unit

---
 rtl/sigmoid_vector_unit.sv | 106 ++++++++++
 tb/tb_sigmoid_vector_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_vector_unit.sv
// rtl/sigmoid_vector_unit.sv - streams NUM_ELEMS elements through a sigmoid LUT into a result memory.
// Optional build macro SIGMOID_SAT_EN: saturate out-of-range elements to the last LUT entry.
module sigmoid_vector_unit #(
    parameter int width          = 8,
    parameter int X_depth_bits   = 3,
    parameter int A_depth_bits   = 3,
    parameter int SIG_depth_bits = 8,
    parameter int NUM_ELEMS      = 8
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      Start,
    output logic                      Busy,
    output logic                      Done,
    output logic                      X_read_en,
    output logic [X_depth_bits-1:0]   X_read_address,
    input  logic [width-1:0]          X_read_data_out,
    output logic                      SIG_read_en,
    output logic [SIG_depth_bits-1:0] SIG_read_address,
    input  logic [width-1:0]          SIG_read_data_out,
    output logic                      A_write_en,
    output logic [A_depth_bits-1:0]   A_write_address,
    output logic [width-1:0]          A_write_data_in
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [X_depth_bits-1:0] LAST_IDX = X_depth_bits'(NUM_ELEMS - 1);

    state_t                    state_q, state_d;
    logic [X_depth_bits-1:0]   cnt_q, cnt_d;
    logic                      sig_vld_q, wr_vld_q;
    logic [X_depth_bits-1:0]   sig_idx_q, wr_idx_q;
    logic [SIG_depth_bits-1:0] sig_addr;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST_IDX) state_d = S_FLUSH;
            // Leave once the write of the final element is on the bus this cycle.
            S_FLUSH: if (wr_vld_q && (wr_idx_q == LAST_IDX)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Busy           = (state_q == S_RUN) || (state_q == S_FLUSH);
        Done           = (state_q == S_DONE);
        X_read_en      = (state_q == S_RUN);
        X_read_address = (state_q == S_RUN) ? cnt_q : '0;
    end

    always_comb begin
        cnt_d = '0;
        if ((state_q == S_RUN) && (cnt_q != LAST_IDX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q     <= '0;
            sig_vld_q <= 1'b0;
            sig_idx_q <= '0;
            wr_vld_q  <= 1'b0;
            wr_idx_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            sig_vld_q <= X_read_en;
            sig_idx_q <= cnt_q;
            wr_vld_q  <= sig_vld_q;
            wr_idx_q  <= sig_idx_q;
        end
    end

    always_comb begin
        sig_addr = X_read_data_out[SIG_depth_bits-1:0];
`ifdef SIGMOID_SAT_EN
        if ((X_read_data_out >> SIG_depth_bits) != '0) begin
            sig_addr = '1;
        end
`endif
    end

    assign SIG_read_en      = sig_vld_q;
    assign SIG_read_address = sig_vld_q ? sig_addr : '0;
    assign A_write_en       = wr_vld_q;
    assign A_write_address  = wr_vld_q ? A_depth_bits'(wr_idx_q) : '0;
    assign A_write_data_in  = wr_vld_q ? SIG_read_data_out : '0;

endmodule

// File: tb/tb_sigmoid_vector_unit.sv
// tb/tb_sigmoid_vector_unit.sv - self-checking bench for sigmoid_vector_unit against a queue-based reference.
module tb_sigmoid_vector_unit;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // DUT 1: default parameters, 8-element jobs
    logic       start1 = 1'b0;
    logic       busy1, done1, xen1, sen1, wen1;
    logic [2:0] xaddr1, waddr1;
    logic [7:0] saddr1, wdata1;
    logic [7:0] xdata1 = '0, sdata1 = '0;
    logic [7:0] xmem1 [8];
    logic [7:0] lut1 [256];

    sigmoid_vector_unit u1 (
        .clk(clk), .aresetn(aresetn), .Start(start1), .Busy(busy1), .Done(done1),
        .X_read_en(xen1), .X_read_address(xaddr1), .X_read_data_out(xdata1),
        .SIG_read_en(sen1), .SIG_read_address(saddr1), .SIG_read_data_out(sdata1),
        .A_write_en(wen1), .A_write_address(waddr1), .A_write_data_in(wdata1)
    );

    // DUT 2: single-element job, narrow LUT
    logic       start2 = 1'b0;
    logic       busy2, done2, xen2, sen2, wen2;
    logic [2:0] xaddr2, waddr2;
    logic [3:0] saddr2;
    logic [7:0] wdata2;
    logic [7:0] xdata2 = '0, sdata2 = '0;
    logic [7:0] xmem2 [8];
    logic [7:0] lut2 [16];

    sigmoid_vector_unit #(.width(8), .X_depth_bits(3), .A_depth_bits(3),
                          .SIG_depth_bits(4), .NUM_ELEMS(1)) u2 (
        .clk(clk), .aresetn(aresetn), .Start(start2), .Busy(busy2), .Done(done2),
        .X_read_en(xen2), .X_read_address(xaddr2), .X_read_data_out(xdata2),
        .SIG_read_en(sen2), .SIG_read_address(saddr2), .SIG_read_data_out(sdata2),
        .A_write_en(wen2), .A_write_address(waddr2), .A_write_data_in(wdata2)
    );

    // Synchronous-read memory models: data returned the cycle after the enable.
    always @(posedge clk) begin
        if (xen1) xdata1 <= xmem1[xaddr1];
        if (sen1) sdata1 <= lut1[saddr1];
        if (xen2) xdata2 <= xmem2[xaddr2];
        if (sen2) sdata2 <= lut2[saddr2];
    end

    int w1_cyc[$], w1_addr[$], w1_data[$], d1_cyc[$], b1_cyc[$];
    int w2_cyc[$], w2_addr[$], w2_data[$], s2_addr[$], d2_cyc[$], b2_cyc[$];

    always @(negedge clk) begin
        if (wen1) begin
            w1_cyc.push_back(cyc); w1_addr.push_back(int'(waddr1)); w1_data.push_back(int'(wdata1));
        end
        if (done1) d1_cyc.push_back(cyc);
        if (busy1) b1_cyc.push_back(cyc);
        if (wen2) begin
            w2_cyc.push_back(cyc); w2_addr.push_back(int'(waddr2)); w2_data.push_back(int'(wdata2));
        end
        if (sen2) s2_addr.push_back(int'(saddr2));
        if (done2) d2_cyc.push_back(cyc);
        if (busy2) b2_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_idx(input int x, input int sb);
`ifdef SIGMOID_SAT_EN
        if ((x >> sb) != 0) return (1 << sb) - 1;
`endif
        return x & ((1 << sb) - 1);
    endfunction

    task automatic clear_logs();
        w1_cyc.delete(); w1_addr.delete(); w1_data.delete(); d1_cyc.delete(); b1_cyc.delete();
        w2_cyc.delete(); w2_addr.delete(); w2_data.delete(); s2_addr.delete();
        d2_cyc.delete(); b2_cyc.delete();
    endtask

    task automatic randomize_mem1();
        for (int i = 0; i < 8; i++) xmem1[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) lut1[i] = 8'($urandom);
    endtask

    // Single Start pulse on DUT 1, optional stray Starts at relative cycles 2 and 5.
    task automatic job1(input bit stray, output int t0);
        clear_logs();
        @(negedge clk); t0 = cyc; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int r = 2; r <= 20; r++) begin
            @(negedge clk);
            start1 = stray && (r == 2 || r == 5);
        end
        start1 = 1'b0;
    endtask

    // Compares n_jobs back-to-back 8-element jobs (each 12 cycles apart) with the reference.
    task automatic check_jobs1(input string tag, input int t0, input int n_jobs);
        check({tag, "_nwrites"}, w1_cyc.size(), 8 * n_jobs);
        check({tag, "_ndone"}, d1_cyc.size(), n_jobs);
        for (int j = 0; j < n_jobs; j++) begin
            if (d1_cyc.size() > j) check({tag, "_done_cyc"}, d1_cyc[j] - t0, 11 + 12 * j);
        end
        for (int k = 0; k < w1_cyc.size() && k < 8 * n_jobs; k++) begin
            check({tag, "_waddr"}, w1_addr[k], k % 8);
            check({tag, "_wdata"}, w1_data[k], int'(lut1[ref_idx(int'(xmem1[k % 8]), 8)]));
            check({tag, "_wcyc"}, w1_cyc[k] - t0, (k % 8) + 3 + 12 * (k / 8));
        end
        check({tag, "_busy_cycles"}, b1_cyc.size(), 10 * n_jobs);
        if (b1_cyc.size() > 0) begin
            check({tag, "_busy_first"}, b1_cyc[0] - t0, 1);
            check({tag, "_busy_last"}, b1_cyc[b1_cyc.size() - 1] - t0, 10 + 12 * (n_jobs - 1));
        end
    endtask

    task automatic job2(input string tag, input logic [7:0] x);
        int t0;
        int idx;
        xmem2[0] = x;
        idx = ref_idx(int'(x), 4);
        clear_logs();
        @(negedge clk); t0 = cyc; start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        repeat (10) @(negedge clk);
        check({tag, "_nsig"}, s2_addr.size(), 1);
        if (s2_addr.size() > 0) check({tag, "_sig_addr"}, s2_addr[0], idx);
        check({tag, "_nwrites"}, w2_cyc.size(), 1);
        if (w2_cyc.size() > 0) begin
            check({tag, "_waddr"}, w2_addr[0], 0);
            check({tag, "_wdata"}, w2_data[0], int'(lut2[idx]));
            check({tag, "_wcyc"}, w2_cyc[0] - t0, 3);
        end
        check({tag, "_ndone"}, d2_cyc.size(), 1);
        if (d2_cyc.size() > 0) check({tag, "_done_cyc"}, d2_cyc[0] - t0, 4);
        check({tag, "_busy_cycles"}, b2_cyc.size(), 3);
        if (b2_cyc.size() > 0) check({tag, "_busy_first"}, b2_cyc[0] - t0, 1);
    endtask

    initial begin
        int t0;
        int wsnap;

        for (int i = 0; i < 8; i++) begin xmem1[i] = 8'(i); xmem2[i] = '0; end
        for (int i = 0; i < 256; i++) lut1[i] = 8'(i + 100);
        for (int i = 0; i < 16; i++) lut2[i] = 8'(i * 7 + 3);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_xen", xen1, 0);
        check("rst_sen", sen1, 0);
        check("rst_wen", wen1, 0);
        check("rst_xaddr", xaddr1, 0);
        check("rst_saddr", saddr1, 0);
        check("rst_waddr", waddr1, 0);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);

        // Identity elements through LUT[i]=i+100
        job1(1'b0, t0);
        check_jobs1("ident", t0, 1);

        // Random contents
        for (int n = 0; n < 3; n++) begin
            randomize_mem1();
            job1(1'b0, t0);
            check_jobs1("rand", t0, 1);
        end

        // Stray Starts during a job
        randomize_mem1();
        job1(1'b1, t0);
        check_jobs1("stray", t0, 1);

        // Start held high for exactly two jobs
        randomize_mem1();
        clear_logs();
        @(negedge clk); t0 = cyc; start1 = 1'b1;
        for (int r = 1; r <= 13; r++) @(negedge clk);
        start1 = 1'b0;
        repeat (20) @(negedge clk);
        check_jobs1("b2b", t0, 2);

        // Reset in the middle of a job
        randomize_mem1();
        clear_logs();
        @(negedge clk); t0 = cyc; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_pre_busy", busy1, 1);
        aresetn = 1'b0;
        #1;
        check("mid_xen", xen1, 0);
        check("mid_sen", sen1, 0);
        check("mid_wen", wen1, 0);
        check("mid_busy", busy1, 0);
        wsnap = w1_cyc.size();
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_no_writes", w1_cyc.size(), wsnap);
        check("mid_no_done", d1_cyc.size(), 0);
        check("mid_idle_xen", xen1, 0);

        // Single-element unit with a 4-bit LUT index
        job2("sat3a", 8'h3A);
        job2("x05", 8'h05);
        for (int n = 0; n < 4; n++) job2("rand2", 8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
